ysyx_22050550_ifu: RTL and testbench

- Instruction-fetch unit; the consumer side of the PC register.
- Takes the fetch address `npc` and issues an AXI4-Lite-style read on the instruction memory port.
- Extracts the 32-bit instruction and presents {pc, inst} to ID under a valid/ready handshake.
- Returns `ready` to the PC register so it advances only when ID accepts the fetched instruction; ID redirects (`flush`) squash in-flight fetches.

---
 rtl/ysyx_22050550_ifu_pkg.sv | 19 +
 rtl/ysyx_22050550_ifu_reg.sv | 24 ++
 rtl/ysyx_22050550_ifu.sv | 135 +++++++++++++
 tb/tb_ysyx_22050550_ifu.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   - ifu_state_e : 2-bit fetch FSM encoding
//   - RespOkay    : AXI read response code for a successful read
//   - RegBus / InstBus : default address/PC and instruction widths
package ysyx_22050550_ifu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StOut  = 2'b11
  } ifu_state_e;

  localparam logic [1:0] RespOkay = 2'b00;

  localparam int unsigned RegBus  = 64;
  localparam int unsigned InstBus = 32;

endpackage

// File: rtl/ysyx_22050550_ifu_reg.sv
// Generic register with write enable and synchronous active-high reset.
//   clock, reset : clock and synchronous reset (loads RESET_VAL)
//   wen          : load din on the next edge
//   din / dout   : data in / registered data out
module ysyx_22050550_ifu_reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction-fetch unit. Latches the fetch address from the PC register, issues a single
// AXI4-Lite-style read, selects the 32-bit half addressed by pc[2] and presents {pc, inst}
// to ID under valid/ready. A redirect (flush) squashes whatever fetch is in flight.
//   clock, reset       : clock, synchronous active-high reset
//   npc, flush, ready  : PC register side (fetch address, redirect, advance strobe)
//   ar* / r*           : instruction memory read port
//   if_* , id_ready    : fetched instruction to ID and its handshake
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = RegBus,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INST_W = InstBus
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] npc,
  input  logic              flush,
  output logic              ready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_fault,
  output logic              if_valid,
  input  logic              id_ready
);

  ifu_state_e state_q;
  logic       discard_q;

  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              fault_q, fault_d;
  logic              pc_wen, data_wen;

  assign pc_wen   = (state_q == StIdle);
  assign data_wen = (state_q == StWait) && rvalid;
  // pc[1:0] is deliberately ignored; pc[2] picks the upper or lower word of the beat.
  assign inst_d   = pc_q[2] ? rdata[INST_W +: INST_W] : rdata[0 +: INST_W];
  assign fault_d  = (rresp != RespOkay);

`ifdef ysyx_22050550_FAST
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (pc_wen) pc_q <= npc;
      if (data_wen) begin
        inst_q  <= inst_d;
        fault_q <= fault_d;
      end
    end
  end
`else
  ysyx_22050550_ifu_reg #(.WIDTH(ADDR_W), .RESET_VAL('0)) u_pc_reg (
    .clock (clock),
    .reset (reset),
    .wen   (pc_wen),
    .din   (npc),
    .dout  (pc_q)
  );

  ysyx_22050550_ifu_reg #(.WIDTH(INST_W), .RESET_VAL('0)) u_inst_reg (
    .clock (clock),
    .reset (reset),
    .wen   (data_wen),
    .din   (inst_d),
    .dout  (inst_q)
  );

  ysyx_22050550_ifu_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_fault_reg (
    .clock (clock),
    .reset (reset),
    .wen   (data_wen),
    .din   (fault_d),
    .dout  (fault_q)
  );
`endif

  // discard remembers a redirect seen while the read was outstanding; the address phase is
  // never withdrawn, so the response still has to be drained before refetching.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StReq;
          discard_q <= 1'b0;
        end
        StReq: begin
          if (flush) discard_q <= 1'b1;
          if (arvalid && arready) state_q <= StWait;
        end
        StWait: begin
          if (rvalid) begin
            state_q   <= (discard_q || flush) ? StIdle : StOut;
            discard_q <= 1'b0;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        StOut: begin
          if (flush || id_ready) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  assign araddr   = pc_q;
  assign arvalid  = (state_q == StReq);
  assign rready   = (state_q == StWait);
  assign if_valid = (state_q == StOut);
  assign if_pc    = pc_q;
  assign if_inst  = inst_q;
  assign if_fault = fault_q;
  assign ready    = (state_q == StOut) && id_ready && !flush;

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
module tb_ysyx_22050550_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] npc;
  logic        flush;
  logic        ready;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;
  logic        if_valid;
  logic        id_ready;

  always #5 clock = ~clock;

  ysyx_22050550_ifu dut (
    .clock    (clock),
    .reset    (reset),
    .npc      (npc),
    .flush    (flush),
    .ready    (ready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_fault (if_fault),
    .if_valid (if_valid),
    .id_ready (id_ready)
  );

  // Memory model: programmable address/data wait states, fixed data/response.
  int          ar_delay;
  int          r_delay;
  logic [63:0] mem_data;
  logic [1:0]  mem_resp;
  logic        pending;
  int          ar_cnt;
  int          r_cnt;

  assign arready = arvalid && !pending && (ar_cnt >= ar_delay);
  assign rvalid  = pending && (r_cnt >= r_delay);
  assign rdata   = mem_data;
  assign rresp   = mem_resp;

  always @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      ar_cnt  <= 0;
      r_cnt   <= 0;
    end else begin
      if (arvalid && arready) begin
        pending <= 1'b1;
        ar_cnt  <= 0;
        r_cnt   <= 0;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) pending <= 1'b0;
      else if (pending) r_cnt <= r_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_out(input int max, output int n);
    n = 0;
    while (!if_valid && n < max) begin
      tick();
      n++;
    end
    chk("wait_if_valid", {63'd0, if_valid}, 64'd1);
  endtask

  // Runs until the next address phase, recording any spurious valid/ready on the way.
  task automatic wait_req(input string name, input logic [63:0] exp_addr);
    logic saw_valid;
    logic saw_ready;
    int   n;
    saw_valid = 1'b0;
    saw_ready = 1'b0;
    n = 0;
    while (!arvalid && n < 20) begin
      saw_valid |= if_valid;
      saw_ready |= ready;
      tick();
      n++;
    end
    chk({name, "_no_valid"}, {63'd0, saw_valid}, 64'd0);
    chk({name, "_no_ready"}, {63'd0, saw_ready}, 64'd0);
    chk({name, "_arvalid"}, {63'd0, arvalid}, 64'd1);
    chk({name, "_araddr"}, araddr, exp_addr);
  endtask

  // Completes the fetch currently in OUT with a single accepted cycle.
  task automatic accept(input string name);
    id_ready = 1'b1;
    #1;
    chk({name, "_ready"}, {63'd0, ready}, 64'd1);
    tick();
    id_ready = 1'b0;
    chk({name, "_ready_after"}, {63'd0, ready}, 64'd0);
    chk({name, "_valid_after"}, {63'd0, if_valid}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] npc;
    logic [63:0] data;
    logic [1:0]  resp;
    int          ar_d;
    int          r_d;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;

    vecs[0] = '{64'h8000_0004, 64'h0010_0093_0000_0513, 2'b00, 0, 0, 32'h0010_0093, 1'b0};
    vecs[1] = '{64'h8000_0008, 64'hdead_beef_1234_5678, 2'b10, 0, 2, 32'h1234_5678, 1'b1};
    vecs[2] = '{64'h8000_000c, 64'hdead_beef_1234_5678, 2'b00, 1, 0, 32'hdead_beef, 1'b0};
    vecs[3] = '{64'h8000_0012, 64'hcafe_f00d_0bad_0bad, 2'b01, 2, 1, 32'h0bad_0bad, 1'b1};
    vecs[4] = '{64'h8000_0016, 64'hcafe_f00d_0bad_0bad, 2'b00, 0, 0, 32'hcafe_f00d, 1'b0};

    reset    = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    npc      = 64'h8000_0000;
    ar_delay = 0;
    r_delay  = 0;
    mem_data = 64'h0010_0093_0000_0513;
    mem_resp = 2'b00;
    repeat (3) tick();
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_if_inst", {32'd0, if_inst}, 64'd0);

    // Reset exit, zero-wait memory: IDLE, REQ, WAIT, OUT.
    reset = 1'b0;
    chk("c1_arvalid", {63'd0, arvalid}, 64'd0);
    tick();
    chk("c2_arvalid", {63'd0, arvalid}, 64'd1);
    chk("c2_araddr", araddr, 64'h8000_0000);
    tick();
    chk("c3_rready", {63'd0, rready}, 64'd1);
    chk("c3_if_valid", {63'd0, if_valid}, 64'd0);
    tick();
    chk("c4_if_valid", {63'd0, if_valid}, 64'd1);
    chk("c4_if_inst", {32'd0, if_inst}, 64'h0000_0513);
    chk("c4_if_pc", if_pc, 64'h8000_0000);
    accept("c4");

    // Table: half-select, faults, wait states and latency.
    for (int i = 0; i < 5; i++) begin
      npc      = vecs[i].npc;
      mem_data = vecs[i].data;
      mem_resp = vecs[i].resp;
      ar_delay = vecs[i].ar_d;
      r_delay  = vecs[i].r_d;
      wait_out(20, n);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(3 + vecs[i].ar_d + vecs[i].r_d));
      chk($sformatf("v%0d_pc", i), if_pc, vecs[i].npc);
      chk($sformatf("v%0d_inst", i), {32'd0, if_inst}, {32'd0, vecs[i].inst});
      chk($sformatf("v%0d_fault", i), {63'd0, if_fault}, {63'd0, vecs[i].fault});
      chk($sformatf("v%0d_ready_stalled", i), {63'd0, ready}, 64'd0);
      accept($sformatf("v%0d", i));
    end
    ar_delay = 0;
    r_delay  = 0;
    mem_resp = 2'b00;

    // ID stall for 5 cycles in OUT.
    npc      = 64'h8000_0008;
    mem_data = 64'h1111_1111_2222_2222;
    wait_out(20, n);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, if_valid}, 64'd1);
      chk("stall_pc", if_pc, 64'h8000_0008);
      chk("stall_inst", {32'd0, if_inst}, 64'h2222_2222);
      chk("stall_ready", {63'd0, ready}, 64'd0);
      tick();
    end
    accept("stall");

    // Flush in WAIT with a slow response.
    npc     = 64'h8000_0010;
    r_delay = 3;
    tick();
    tick();
    chk("fw_rready", {63'd0, rready}, 64'd1);
    flush = 1'b1;
    npc   = 64'h8000_0100;
    #1;
    chk("fw_ready", {63'd0, ready}, 64'd0);
    tick();
    flush = 1'b0;
    wait_req("fw", 64'h8000_0100);
    r_delay  = 0;
    mem_data = 64'h0000_0000_00a0_0113;
    wait_out(20, n);
    chk("fw_new_pc", if_pc, 64'h8000_0100);
    chk("fw_new_inst", {32'd0, if_inst}, 64'h00a0_0113);
    accept("fw_new");

    // Flush in the same cycle as arready.
    npc = 64'h8000_0020;
    tick();
    chk("fa_arvalid", {63'd0, arvalid}, 64'd1);
    chk("fa_arready", {63'd0, arready}, 64'd1);
    chk("fa_araddr", araddr, 64'h8000_0020);
    flush = 1'b1;
    npc   = 64'h8000_0200;
    tick();
    flush = 1'b0;
    wait_req("fa", 64'h8000_0200);
    mem_data = 64'h0000_0000_0020_0193;
    wait_out(20, n);
    chk("fa_new_pc", if_pc, 64'h8000_0200);
    chk("fa_new_inst", {32'd0, if_inst}, 64'h0020_0193);
    accept("fa_new");

    // Flush in OUT, even with id_ready high.
    npc = 64'h8000_0030;
    wait_out(20, n);
    flush    = 1'b1;
    id_ready = 1'b1;
    npc      = 64'h8000_0300;
    #1;
    chk("fo_ready", {63'd0, ready}, 64'd0);
    tick();
    flush    = 1'b0;
    id_ready = 1'b0;
    chk("fo_if_valid", {63'd0, if_valid}, 64'd0);
    chk("fo_idle_arvalid", {63'd0, arvalid}, 64'd0);
    tick();
    chk("fo_arvalid", {63'd0, arvalid}, 64'd1);
    chk("fo_araddr", araddr, 64'h8000_0300);
    wait_out(20, n);
    chk("fo_new_pc", if_pc, 64'h8000_0300);
    accept("fo_new");

    // Reset during an outstanding read.
    npc     = 64'h8000_0038;
    r_delay = 3;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mr_rready", {63'd0, rready}, 64'd0);
    chk("mr_arvalid", {63'd0, arvalid}, 64'd0);
    chk("mr_if_valid", {63'd0, if_valid}, 64'd0);
    reset    = 1'b0;
    r_delay  = 0;
    npc      = 64'h8000_0040;
    mem_data = 64'h0000_0000_0030_0213;
    wait_out(20, n);
    chk("mr_latency", 64'(n), 64'd3);
    chk("mr_pc", if_pc, 64'h8000_0040);
    chk("mr_inst", {32'd0, if_inst}, 64'h0030_0213);
    accept("mr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
